// File: rtl/sym_vn_rank_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : sym_vn_rank_bank_if
// Description : Bus bundle for the symbol variable-node rank LUT bank.
//               Carries the four read ports (message inputs, frame selects,
//               decoded addresses, read data) and the shared write port.
//               The "master" modport drives messages and write traffic;
//               the "slave" modport is the LUT bank itself.
// Ports       : y0_in_A..D        sign-folded magnitude of first message
//               y1_in_A..D        second message
//               page_addr_offset_0..3  frame select per read port
//               lut_data0..3      read data per port
//               page_addr_A..D / bank_addr_A..D  decoded read addresses
//               lut_in_bank0/1, page_write_addr, write_addr_offset, we
// Revision    : 1.0 - initial release
// ============================================================================
interface sym_vn_rank_bank_if #(
    parameter int QUAN_SIZE       = 3,
    parameter int LUT_PORT_SIZE   = 3,
    parameter int ENTRY_ADDR      = 5,
    parameter int MULTI_FRAME_NUM = 2
);
    localparam int c_PW = ENTRY_ADDR - $clog2(MULTI_FRAME_NUM);

    // read-port inputs
    logic [LUT_PORT_SIZE-2:0] y0_in_A, y0_in_B, y0_in_C, y0_in_D;
    logic [QUAN_SIZE-1:0]     y1_in_A, y1_in_B, y1_in_C, y1_in_D;
    logic                     page_addr_offset_0, page_addr_offset_1;
    logic                     page_addr_offset_2, page_addr_offset_3;

    // read-port outputs
    logic [LUT_PORT_SIZE-1:0] lut_data0, lut_data1, lut_data2, lut_data3;
    logic [c_PW-1:0]          page_addr_A, page_addr_B, page_addr_C, page_addr_D;
    logic                     bank_addr_A, bank_addr_B, bank_addr_C, bank_addr_D;

    // write port
    logic [LUT_PORT_SIZE-1:0] lut_in_bank0, lut_in_bank1;
    logic [c_PW-1:0]          page_write_addr;
    logic                     write_addr_offset;
    logic                     we;

    modport master (
        output y0_in_A, y0_in_B, y0_in_C, y0_in_D,
        output y1_in_A, y1_in_B, y1_in_C, y1_in_D,
        output page_addr_offset_0, page_addr_offset_1,
        output page_addr_offset_2, page_addr_offset_3,
        output lut_in_bank0, lut_in_bank1, page_write_addr, write_addr_offset, we,
        input  lut_data0, lut_data1, lut_data2, lut_data3,
        input  page_addr_A, page_addr_B, page_addr_C, page_addr_D,
        input  bank_addr_A, bank_addr_B, bank_addr_C, bank_addr_D
    );

    modport slave (
        input  y0_in_A, y0_in_B, y0_in_C, y0_in_D,
        input  y1_in_A, y1_in_B, y1_in_C, y1_in_D,
        input  page_addr_offset_0, page_addr_offset_1,
        input  page_addr_offset_2, page_addr_offset_3,
        input  lut_in_bank0, lut_in_bank1, page_write_addr, write_addr_offset, we,
        output lut_data0, lut_data1, lut_data2, lut_data3,
        output page_addr_A, page_addr_B, page_addr_C, page_addr_D,
        output bank_addr_A, bank_addr_B, bank_addr_C, bank_addr_D
    );
endinterface
`default_nettype wire

// File: rtl/sym_vn_rank_bank.sv
`default_nettype none
// ============================================================================
// Module      : sym_vn_rank_bank
// Description : Two-bank, multi-frame lookup table for symbol variable-node
//               ranking. Each of four independent read ports forms an index
//               {y0, y1}; its LSB picks the bank, the remaining bits pick the
//               page, and the per-port offset picks the frame. Reads are
//               purely combinational. One shared write port updates the same
//               {offset, page} word in both banks on a rising read_clk.
// Ports       : read_clk  sole clock
//               rstn      asynchronous active-low reset, clears both banks
//               bus       sym_vn_rank_bank_if.slave (read ports + write port)
// Revision    : 1.0 - initial release
// ============================================================================
module sym_vn_rank_bank #(
    parameter int QUAN_SIZE       = 3,
    parameter int LUT_PORT_SIZE   = 3,
    parameter int ENTRY_ADDR      = 5,
    parameter int MULTI_FRAME_NUM = 2
) (
    input  wire logic         read_clk,
    input  wire logic         rstn,
    sym_vn_rank_bank_if.slave bus
);
    localparam int c_PW     = ENTRY_ADDR - $clog2(MULTI_FRAME_NUM);
    localparam int c_AW     = c_PW + 1;           // {offset, page}
    localparam int c_DEPTH  = 1 << c_AW;
    localparam int c_NPORTS = 4;

    // ------------------------------------------------------------------
    // Elaboration guards: the message widths must tile the index exactly,
    // and the single offset bit per port only addresses two frames, which
    // is what makes the page field (index minus bank bit) equal to PW.
    // ------------------------------------------------------------------
    generate
        if ((LUT_PORT_SIZE - 1) + QUAN_SIZE != ENTRY_ADDR) begin : g_bad_index_width
            $error("sym_vn_rank_bank: (LUT_PORT_SIZE-1)+QUAN_SIZE must equal ENTRY_ADDR");
        end
        if (c_PW != ENTRY_ADDR - 1) begin : g_bad_frame_count
            $error("sym_vn_rank_bank: one offset bit supports exactly two frames");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [LUT_PORT_SIZE-1:0] r_bank0 [c_DEPTH];
    logic [LUT_PORT_SIZE-1:0] r_bank1 [c_DEPTH];

    logic [c_AW-1:0] w_waddr;
    assign w_waddr = {bus.write_addr_offset, bus.page_write_addr};

    // Both banks share one write address; reset wipes every word so that
    // any frame read right after reset returns zero.
    always_ff @(posedge read_clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_bank0[i] <= '0;
                r_bank1[i] <= '0;
            end
        end else if (bus.we) begin
            r_bank0[w_waddr] <= bus.lut_in_bank0;
            r_bank1[w_waddr] <= bus.lut_in_bank1;
        end
    end

    // ------------------------------------------------------------------
    // Read ports: gather the named interface signals into arrays so the
    // decode/mux logic is written once.
    // ------------------------------------------------------------------
    logic [LUT_PORT_SIZE-2:0] w_y0    [c_NPORTS];
    logic [QUAN_SIZE-1:0]     w_y1    [c_NPORTS];
    logic                     w_off   [c_NPORTS];
    logic [ENTRY_ADDR-1:0]    w_index [c_NPORTS];
    logic [c_PW-1:0]          w_page  [c_NPORTS];
    logic                     w_bank  [c_NPORTS];
    logic [c_AW-1:0]          w_raddr [c_NPORTS];
    logic [LUT_PORT_SIZE-1:0] w_rdata [c_NPORTS];

    assign w_y0[0]  = bus.y0_in_A;
    assign w_y0[1]  = bus.y0_in_B;
    assign w_y0[2]  = bus.y0_in_C;
    assign w_y0[3]  = bus.y0_in_D;
    assign w_y1[0]  = bus.y1_in_A;
    assign w_y1[1]  = bus.y1_in_B;
    assign w_y1[2]  = bus.y1_in_C;
    assign w_y1[3]  = bus.y1_in_D;
    assign w_off[0] = bus.page_addr_offset_0;
    assign w_off[1] = bus.page_addr_offset_1;
    assign w_off[2] = bus.page_addr_offset_2;
    assign w_off[3] = bus.page_addr_offset_3;

    genvar gi;
    generate
        for (gi = 0; gi < c_NPORTS; gi++) begin : g_port
            // y0 occupies the MSBs; the index LSB steers between banks so
            // adjacent y1 values land in the same page of opposite banks.
            assign w_index[gi] = {w_y0[gi], w_y1[gi]};
            assign w_bank[gi]  = w_index[gi][0];
            assign w_page[gi]  = w_index[gi][ENTRY_ADDR-1:1];
            assign w_raddr[gi] = {w_off[gi], w_page[gi]};
            // No output register and no write bypass: data changes only
            // when the array itself changes at the clock edge.
            assign w_rdata[gi] = w_bank[gi] ? r_bank1[w_raddr[gi]] : r_bank0[w_raddr[gi]];
        end
    endgenerate

    assign bus.lut_data0   = w_rdata[0];
    assign bus.lut_data1   = w_rdata[1];
    assign bus.lut_data2   = w_rdata[2];
    assign bus.lut_data3   = w_rdata[3];
    assign bus.page_addr_A = w_page[0];
    assign bus.page_addr_B = w_page[1];
    assign bus.page_addr_C = w_page[2];
    assign bus.page_addr_D = w_page[3];
    assign bus.bank_addr_A = w_bank[0];
    assign bus.bank_addr_B = w_bank[1];
    assign bus.bank_addr_C = w_bank[2];
    assign bus.bank_addr_D = w_bank[3];

endmodule
`default_nettype wire

// File: tb/tb_sym_vn_rank_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_sym_vn_rank_bank
// Description : Self-checking bench for sym_vn_rank_bank. Directed scenarios
//               (reset, frame isolation, concurrent reads, write timing,
//               full fill then reset) followed by randomized traffic. The
//               reference keeps each bank as a plain array of 2*2^PW words
//               and decodes addresses arithmetically from y0, y1, offset.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sym_vn_rank_bank;
    localparam int QUAN_SIZE       = 3;
    localparam int LUT_PORT_SIZE   = 3;
    localparam int ENTRY_ADDR      = 5;
    localparam int MULTI_FRAME_NUM = 2;
    localparam int Y0W             = LUT_PORT_SIZE - 1;
    localparam int PW              = ENTRY_ADDR - $clog2(MULTI_FRAME_NUM);
    localparam int FRAME_WORDS     = 1 << PW;
    localparam int NWORDS          = MULTI_FRAME_NUM * FRAME_WORDS;

    logic read_clk = 1'b0;
    logic rstn     = 1'b0;
    always #5 read_clk = ~read_clk;

    sym_vn_rank_bank_if #(
        .QUAN_SIZE(QUAN_SIZE), .LUT_PORT_SIZE(LUT_PORT_SIZE),
        .ENTRY_ADDR(ENTRY_ADDR), .MULTI_FRAME_NUM(MULTI_FRAME_NUM)
    ) bus ();

    sym_vn_rank_bank #(
        .QUAN_SIZE(QUAN_SIZE), .LUT_PORT_SIZE(LUT_PORT_SIZE),
        .ENTRY_ADDR(ENTRY_ADDR), .MULTI_FRAME_NUM(MULTI_FRAME_NUM)
    ) dut (
        .read_clk (read_clk),
        .rstn     (rstn),
        .bus      (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int m_bank0 [NWORDS];
    int m_bank1 [NWORDS];
    int ps_y0 [4];
    int ps_y1 [4];
    int ps_off [4];
    int ws_page, ws_off, ws_d0, ws_d1, ws_we;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NWORDS; i++) begin
            m_bank0[i] = 0;
            m_bank1[i] = 0;
        end
    endtask

    task automatic set_port(input int p, input int y0, input int y1, input int off);
        logic [Y0W-1:0]       a;
        logic [QUAN_SIZE-1:0] b;
        logic                 c;
        a = Y0W'(y0);
        b = QUAN_SIZE'(y1);
        c = 1'(off);
        ps_y0[p]  = int'(a);
        ps_y1[p]  = int'(b);
        ps_off[p] = int'(c);
        case (p)
            0: begin bus.y0_in_A = a; bus.y1_in_A = b; bus.page_addr_offset_0 = c; end
            1: begin bus.y0_in_B = a; bus.y1_in_B = b; bus.page_addr_offset_1 = c; end
            2: begin bus.y0_in_C = a; bus.y1_in_C = b; bus.page_addr_offset_2 = c; end
            default: begin bus.y0_in_D = a; bus.y1_in_D = b; bus.page_addr_offset_3 = c; end
        endcase
    endtask

    // word address a in 0..63 -> port inputs: a/32 is the frame, a%32 the
    // table entry {y0,y1}
    task automatic set_port_flat(input int p, input int a);
        set_port(p, (a % 32) / (1 << QUAN_SIZE), (a % 32) % (1 << QUAN_SIZE), a / 32);
    endtask

    task automatic set_write(input int page, input int off, input int d0, input int d1, input int we);
        ws_page = page % FRAME_WORDS;
        ws_off  = off % 2;
        ws_d0   = d0 % (1 << LUT_PORT_SIZE);
        ws_d1   = d1 % (1 << LUT_PORT_SIZE);
        ws_we   = we % 2;
        bus.page_write_addr   = PW'(ws_page);
        bus.write_addr_offset = 1'(ws_off);
        bus.lut_in_bank0      = LUT_PORT_SIZE'(ws_d0);
        bus.lut_in_bank1      = LUT_PORT_SIZE'(ws_d1);
        bus.we                = 1'(ws_we);
    endtask

    // one rising edge; the model commits the write only when reset is off
    task automatic tick();
        @(posedge read_clk);
        if (rstn === 1'b1 && ws_we == 1) begin
            m_bank0[ws_off * FRAME_WORDS + ws_page] = ws_d0;
            m_bank1[ws_off * FRAME_WORDS + ws_page] = ws_d1;
        end
        #1;
    endtask

    function automatic int exp_data(input int y0, input int y1, input int off);
        int idx;
        int addr;
        idx  = y0 * (1 << QUAN_SIZE) + y1;
        addr = off * FRAME_WORDS + idx / 2;
        return (idx % 2 == 1) ? m_bank1[addr] : m_bank0[addr];
    endfunction

    task automatic check_ports(input string tag);
        for (int p = 0; p < 4; p++) begin
            logic [31:0] obs_d, obs_pg, obs_bk;
            int idx;
            case (p)
                0: begin obs_d = 32'(bus.lut_data0); obs_pg = 32'(bus.page_addr_A); obs_bk = 32'(bus.bank_addr_A); end
                1: begin obs_d = 32'(bus.lut_data1); obs_pg = 32'(bus.page_addr_B); obs_bk = 32'(bus.bank_addr_B); end
                2: begin obs_d = 32'(bus.lut_data2); obs_pg = 32'(bus.page_addr_C); obs_bk = 32'(bus.bank_addr_C); end
                default: begin obs_d = 32'(bus.lut_data3); obs_pg = 32'(bus.page_addr_D); obs_bk = 32'(bus.bank_addr_D); end
            endcase
            idx = ps_y0[p] * (1 << QUAN_SIZE) + ps_y1[p];
            check_eq($sformatf("%s_p%0d_page", tag, p), obs_pg, idx / 2);
            check_eq($sformatf("%s_p%0d_bank", tag, p), obs_bk, idx % 2);
            check_eq($sformatf("%s_p%0d_data", tag, p), obs_d, exp_data(ps_y0[p], ps_y1[p], ps_off[p]));
        end
    endtask

    // walk all 64 words, four ports at a time, away from the rising edge
    task automatic sweep(input string tag);
        for (int g = 0; g < NWORDS * 2; g += 4) begin
            @(negedge read_clk);
            for (int p = 0; p < 4; p++) set_port_flat(p, g + p);
            #1 check_ports(tag);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_model();
        for (int p = 0; p < 4; p++) set_port(p, 0, 0, 0);
        set_write(0, 0, 0, 0, 0);
        rstn = 1'b0;
        tick();

        // reset held: reads are zero, addresses still decode, writes ignored
        for (int k = 0; k < 4; k++) begin
            for (int p = 0; p < 4; p++)
                set_port(p, $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 1));
            set_write($urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(1, 7), $urandom_range(1, 7), 1);
            #1 check_ports("in_reset");
            tick();
        end
        rstn = 1'b1;
        set_write(0, 0, 0, 0, 0);
        for (int p = 0; p < 4; p++) set_port(p, 0, 0, 0);
        #1 check_ports("post_reset");

        // first write, then read both banks of page 0101 on port A
        set_write(5, 0, 6, 2, 1);
        tick();
        set_write(5, 0, 6, 2, 0);
        set_port(0, 1, 2, 0);
        #1;
        check_eq("a_page_0101", 32'(bus.page_addr_A), 5);
        check_eq("a_bank_even", 32'(bus.bank_addr_A), 0);
        check_eq("a_data_bank0", 32'(bus.lut_data0), 6);
        set_port(0, 1, 3, 0);
        #1;
        check_eq("a_bank_odd", 32'(bus.bank_addr_A), 1);
        check_eq("a_data_bank1", 32'(bus.lut_data0), 2);

        // frame isolation
        set_port(0, 1, 2, 1);
        #1 check_eq("off1_unwritten_b0", 32'(bus.lut_data0), 0);
        set_port(0, 1, 3, 1);
        #1 check_eq("off1_unwritten_b1", 32'(bus.lut_data0), 0);
        set_write(5, 1, 5, 7, 1);
        tick();
        set_write(5, 1, 5, 7, 0);
        set_port(0, 1, 2, 1);
        set_port(1, 1, 3, 1);
        set_port(2, 1, 2, 0);
        set_port(3, 1, 3, 0);
        #1;
        check_eq("off1_b0", 32'(bus.lut_data0), 5);
        check_eq("off1_b1", 32'(bus.lut_data1), 7);
        check_eq("off0_kept_b0", 32'(bus.lut_data2), 6);
        check_eq("off0_kept_b1", 32'(bus.lut_data3), 2);
        check_ports("frames");

        // four ports at four different written addresses, then one address
        set_write(0, 0, 3, 4, 1);  tick();
        set_write(10, 0, 1, 5, 1); tick();
        set_write(15, 1, 7, 6, 1); tick();
        set_write(0, 0, 0, 0, 0);
        set_port(0, 0, 0, 0);
        set_port(1, 2, 5, 0);
        set_port(2, 3, 7, 1);
        set_port(3, 1, 2, 1);
        #1;
        check_eq("conc_A", 32'(bus.lut_data0), 3);
        check_eq("conc_B", 32'(bus.lut_data1), 5);
        check_eq("conc_C", 32'(bus.lut_data2), 6);
        check_eq("conc_D", 32'(bus.lut_data3), 5);
        check_ports("conc");
        for (int p = 0; p < 4; p++) set_port(p, 1, 3, 1);
        #1;
        check_eq("same_A", 32'(bus.lut_data0), 7);
        check_eq("same_D", 32'(bus.lut_data3), 7);
        check_ports("same");

        // we=0 with fresh data on the bus
        set_write(5, 0, 1, 4, 0);
        tick();
        set_port(0, 1, 2, 0);
        set_port(1, 1, 3, 0);
        #1;
        check_eq("we0_b0", 32'(bus.lut_data0), 6);
        check_eq("we0_b1", 32'(bus.lut_data1), 2);

        // write while reading the same word: old before edge, new after
        set_write(5, 0, 3, 1, 1);
        #1;
        check_eq("rw_old_b0", 32'(bus.lut_data0), 6);
        check_eq("rw_old_b1", 32'(bus.lut_data1), 2);
        tick();
        set_write(5, 0, 3, 1, 0);
        check_eq("rw_new_b0", 32'(bus.lut_data0), 3);
        check_eq("rw_new_b1", 32'(bus.lut_data1), 1);

        // populate every word, then reset between edges
        for (int a = 0; a < NWORDS; a++) begin
            set_write(a % FRAME_WORDS, a / FRAME_WORDS, (a % 7) + 1, ((a + 3) % 7) + 1, 1);
            tick();
        end
        set_write(0, 0, 0, 0, 0);
        sweep("full");
        @(negedge read_clk);
        #2;
        rstn = 1'b0;
        clear_model();
        #1 check_ports("pulse_rst");
        set_write(3, 1, 4, 6, 1);    // must not land while reset is low
        tick();
        set_write(0, 0, 0, 0, 0);
        sweep("rst_low");
        @(negedge read_clk);
        rstn = 1'b1;
        set_write(9, 1, 4, 0, 1);
        tick();
        set_write(0, 0, 0, 0, 0);
        sweep("one_word");
        set_port_flat(0, 32 + 18);   // frame 1, entry {y0,y1}=18 -> page 9, bank 0
        #1 check_eq("one_word_value", 32'(bus.lut_data0), 4);

        // randomized traffic with occasional asynchronous reset pulses
        tick();
        for (int it = 0; it < 400; it++) begin
            for (int p = 0; p < 4; p++)
                set_port(p, $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0)
                for (int p = 1; p < 4; p++) set_port(p, ps_y0[0], ps_y1[0], ps_off[0]);
            set_write($urandom_range(0, 15), $urandom_range(0, 1),
                      $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1));
            #1 check_ports("rnd_pre");
            if ($urandom_range(0, 29) == 0) begin
                rstn = 1'b0;
                clear_model();
                #1 check_ports("rnd_rst");
                #1 rstn = 1'b1;
            end
            tick();
            check_ports("rnd_post");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sym_vn_rank_bank.md
SYM_VN_RANK_BANK -- requirements
Module: sym_vn_rank_bank

Interface
REQ-001 SHALL have parameter QUAN_SIZE, default 3, width of incoming message y1.
REQ-002 SHALL have parameter LUT_PORT_SIZE, default 3, width of each LUT word.
REQ-003 SHALL have parameter ENTRY_ADDR, default 5, number of entry-index bits per table.
REQ-004 SHALL have parameter MULTI_FRAME_NUM, default 2, number of tables (frames) held; derived PW = ENTRY_ADDR - clog2(MULTI_FRAME_NUM), default 4.
REQ-005 SHALL have exactly one clock and an asynchronous active-low reset.
REQ-006 read_clk  in  1  sole clock; all writes sampled on its rising edge.
REQ-007 rstn  in  1  asynchronous active-low reset.
REQ-008 y0_in_A..y0_in_D  in  LUT_PORT_SIZE-1 each  sign-folded magnitude of first message, ports A-D.
REQ-009 y1_in_A..y1_in_D  in  QUAN_SIZE each  second message, ports A-D.
REQ-010 page_addr_offset_0..3  in  1 each  frame select for read ports A-D.
REQ-011 lut_data0..lut_data3  out  LUT_PORT_SIZE each  read data, ports A-D.
REQ-012 page_addr_A..D  out  PW each; bank_addr_A..D  out  1 each  decoded read addresses, exposed for observation.
REQ-013 lut_in_bank0, lut_in_bank1  in  LUT_PORT_SIZE each  write data for bank 0 / bank 1.
REQ-014 page_write_addr  in  PW  write page; write_addr_offset  in  1  write frame select.
REQ-015 we  in  1  write enable, active high.

Function
REQ-016 SHALL form, per port, index = {y0_in, y1_in} (y0 in MSBs), ENTRY_ADDR bits total; elaboration SHALL fail if (LUT_PORT_SIZE-1)+QUAN_SIZE != ENTRY_ADDR.
REQ-017 SHALL drive bank_addr = index[0] and page_addr = index[ENTRY_ADDR-1:1], purely combinational.
REQ-018 SHALL hold two banks, each MULTI_FRAME_NUM*2^PW words (default 32) of LUT_PORT_SIZE bits, word address = {offset, page}.
REQ-019 Each read port SHALL output bank1[{offset,page}] when bank_addr=1, else bank0[{offset,page}], combinationally (zero-cycle latency, no output register).
REQ-020 All four read ports SHALL operate independently and concurrently, including identical addresses.
REQ-021 On rising read_clk with we=1 and rstn=1, SHALL write lut_in_bank0 to bank0 and lut_in_bank1 to bank1, both at {write_addr_offset, page_write_addr}.
REQ-022 we=0 SHALL leave all contents unchanged.
REQ-023 Read of an address being written SHALL return old data before the edge and new data immediately after it (no bypass).
REQ-024 Offset bit SHALL fully isolate frames: a write with offset 0 SHALL never alter any offset-1 word, and vice versa.

Reset
REQ-025 rstn=0 SHALL asynchronously clear every word of both banks to 0; lut_data0..3 therefore read 0 immediately.
REQ-026 While rstn=0, writes SHALL be ignored; address outputs remain combinational functions of inputs.
REQ-027 Reset asserted mid-operation SHALL discard all prior writes; first write accepted on the first rising edge with rstn=1.

Verification
REQ-028 Reset then any y0/y1/offset on all ports -> lut_data0..3 = 0.
REQ-029 we=1, page_write_addr=4'b0101, write_addr_offset=0, bank0=3'd6, bank1=3'd2, one edge; port A y0=2'b01,y1=3'b010,offset 0 -> page_addr_A=0101, bank_addr_A=0, lut_data0=6; y1=3'b011 -> bank_addr_A=1, lut_data0=2.
REQ-030 After REQ-029, same y0/y1 with offset 1 -> lut_data0=0; write page 0101 offset 1 with 3'd5/3'd7 -> offset 1 reads 5/7, offset 0 still 6/2.
REQ-031 Ports A-D concurrently at four different written addresses -> each returns its own word in the same cycle; all four at one address -> identical data.
REQ-032 we=0 with new data on an edge -> contents unchanged; write and read same address -> old value before edge, new after.
REQ-033 Populate all 64 words with distinct-per-bank patterns, pulse rstn low between edges -> all outputs 0 at once; rewrite one word -> only that word nonzero.
